// File: rtl/case_9_prod_accum.sv
// ----------------------------------------------------------------------------
// case_9_prod_accum
//
// Accumulation stage behind the case_9 6-bit signed multiplier. A job is
// started with ap_start while idle. The block then sums `len` signed products,
// taking one per prod_vld/prod_ack beat, into a saturating accumulator. It
// presents the final sum on acc_out/acc_vld until the consumer raises acc_ack.
//
// Ports
//   ap_clk     : clock, all state changes on the rising edge
//   ap_rst     : synchronous active-high reset
//   ap_start   : job request, sampled only while idle
//   len        : job length in products, latched on an accepted start
//   prod_dout  : signed product from the multiplier
//   prod_vld   : prod_dout valid
//   prod_ack   : block accepts prod_dout this cycle (decoded from state only)
//   acc_out    : signed accumulated result (registered)
//   acc_vld    : acc_out valid
//   acc_ack    : consumer accepts acc_out
//   sat_flag   : sticky, a clamp happened during the current or last job
//   ap_idle    : block is idle
//   ap_done    : one-cycle pulse coinciding with the return to idle
// ----------------------------------------------------------------------------
module case_9_prod_accum #(
    parameter int PROD_WIDTH = 6,
    parameter int ACC_WIDTH  = 12,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [PROD_WIDTH-1:0] prod_dout,
    input  logic                  prod_vld,
    output logic                  prod_ack,
    output logic [ACC_WIDTH-1:0]  acc_out,
    output logic                  acc_vld,
    input  logic                  acc_ack,
    output logic                  sat_flag,
    output logic                  ap_idle,
    output logic                  ap_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [LEN_WIDTH-1:0]   len_reg,   len_next;
    logic [LEN_WIDTH-1:0]   cnt_reg,   cnt_next;
    logic [ACC_WIDTH-1:0]   acc_reg,   acc_next;
    logic                   sat_reg,   sat_next;
    logic                   done_reg,  done_next;

    // Sign-extended product, one bit wider than the accumulator so the
    // raw sum can never wrap.
    logic [ACC_WIDTH:0]     prod_ext;
    logic [ACC_WIDTH:0]     sum_wide;
    logic [ACC_WIDTH-1:0]   sum_sat;
    logic                   sum_ovf;
    logic [LEN_WIDTH-1:0]   cnt_inc;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    assign prod_ext[PROD_WIDTH-1:0] = prod_dout;

    generate
        for (genvar gi = PROD_WIDTH; gi <= ACC_WIDTH; gi++) begin : g_sext
            assign prod_ext[gi] = prod_dout[PROD_WIDTH-1];
        end
    endgenerate

    assign sum_wide = {acc_reg[ACC_WIDTH-1], acc_reg} + prod_ext;

    // The two top bits of the wide sum disagree exactly when the result does
    // not fit in ACC_WIDTH bits; the top bit then gives the clamp direction.
    assign sum_ovf = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    assign sum_sat = !sum_ovf            ? sum_wide[ACC_WIDTH-1:0] :
                     sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;

    assign cnt_inc = cnt_reg + LEN_WIDTH'(1);

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        sat_next   = sat_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (ap_start) begin
                    len_next   = len;
                    cnt_next   = '0;
                    acc_next   = '0;
                    sat_next   = 1'b0;
                    // An empty job goes straight to presenting a zero result.
                    state_next = (len != '0) ? ACC : OUT;
                end
            end
            ACC: begin
                if (prod_vld) begin
                    acc_next = sum_sat;
                    cnt_next = cnt_inc;
                    if (sum_ovf) begin
                        sat_next = 1'b1;
                    end
                    if (cnt_inc == len_reg) begin
                        state_next = OUT;
                    end
                end
            end
            OUT: begin
                if (acc_ack) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_reg <= IDLE;
            len_reg   <= '0;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            sat_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            sat_reg   <= sat_next;
            done_reg  <= done_next;
        end
    end

    // All handshake/status outputs come straight from registers.
    assign prod_ack = (state_reg == ACC);
    assign acc_vld  = (state_reg == OUT);
    assign ap_idle  = (state_reg == IDLE);
    assign ap_done  = done_reg;
    assign acc_out  = acc_reg;
    assign sat_flag = sat_reg;

endmodule

// File: tb/tb_case_9_prod_accum.sv
// ----------------------------------------------------------------------------
// tb_case_9_prod_accum
//
// Self-checking bench for case_9_prod_accum. Each job pushes its expected
// result (saturating sum and sat flag) onto a scoreboard queue; a monitor
// pops and compares whenever the DUT completes an acc_vld/acc_ack handshake.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ----------------------------------------------------------------------------
module tb_case_9_prod_accum;

    localparam int PW = 6;
    localparam int AW = 12;
    localparam int LW = 8;

    typedef struct {
        int acc;
        int sat;
    } exp_t;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          ap_start;
    logic [LW-1:0] len;
    logic [PW-1:0] prod_dout;
    logic          prod_vld;
    logic          prod_ack;
    logic [AW-1:0] acc_out;
    logic          acc_vld;
    logic          acc_ack;
    logic          sat_flag;
    logic          ap_idle;
    logic          ap_done;

    int   err_cnt  = 0;
    int   chk_cnt  = 0;
    int   beats    = 0;
    int   results  = 0;
    exp_t sb_q[$];
    int   prod_q[$];

    case_9_prod_accum #(
        .PROD_WIDTH(PW),
        .ACC_WIDTH (AW),
        .LEN_WIDTH (LW)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start),
        .len      (len),
        .prod_dout(prod_dout),
        .prod_vld (prod_vld),
        .prod_ack (prod_ack),
        .acc_out  (acc_out),
        .acc_vld  (acc_vld),
        .acc_ack  (acc_ack),
        .sat_flag (sat_flag),
        .ap_idle  (ap_idle),
        .ap_done  (ap_done)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Scoreboard monitor: beat counter and result comparison.
    always @(negedge ap_clk) begin
        if (!ap_rst && prod_vld && prod_ack) begin
            beats++;
        end
        if (!ap_rst && acc_vld && acc_ack) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_acc_out", $signed(acc_out), e.acc);
                check("sb_sat_flag", int'(sat_flag), e.sat);
                results++;
            end
        end
    end

    task automatic wait_idle();
        int c = 0;
        while (!ap_idle && c < 200) begin
            @(posedge ap_clk); #1;
            c++;
        end
        if (!ap_idle) check("idle_timeout", 0, 1);
    endtask

    // Runs one job using the products in prod_q. stall toggles prod_vld every
    // other cycle; ack_wait holds acc_ack low that many extra cycles while
    // ap_start is pulsed (and must be ignored).
    task automatic run_job(input int n, input bit stall, input int ack_wait);
        int   exp_acc = 0;
        int   exp_sat = 0;
        int   idx = 0;
        int   cyc = 0;
        int   held;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            exp_acc += prod_q[i];
            if (exp_acc > 2047) begin
                exp_acc = 2047;
                exp_sat = 1;
            end else if (exp_acc < -2048) begin
                exp_acc = -2048;
                exp_sat = 1;
            end
        end
        e.acc = exp_acc;
        e.sat = exp_sat;
        sb_q.push_back(e);

        wait_idle();
        ap_start = 1'b1;
        len      = LW'(n);
        beats    = 0;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        len      = LW'($urandom);

        while (idx < n && cyc < 1000) begin
            prod_vld  = stall ? (cyc % 2 == 0) : 1'b1;
            prod_dout = PW'(prod_q[idx]);
            @(negedge ap_clk);
            if (prod_vld && prod_ack) idx++;
            @(posedge ap_clk); #1;
            cyc++;
        end
        if (idx < n) check("beat_timeout", idx, n);
        if (!stall) check("latency_cycles", cyc, n);

        // Offer an extra product in the first OUT cycle; it must be refused.
        prod_vld  = 1'b1;
        prod_dout = PW'(31);
        @(negedge ap_clk);
        check("acc_vld_at_T1_len", int'(acc_vld), 1);
        check("prod_ack_in_out", int'(prod_ack), 0);
        held = $signed(acc_out);

        for (int k = 0; k < ack_wait; k++) begin
            @(posedge ap_clk); #1;
            ap_start = 1'b1;
            prod_vld = 1'b0;
            @(negedge ap_clk);
            check("bp_acc_vld", int'(acc_vld), 1);
            check("bp_acc_out_stable", $signed(acc_out), held);
            check("bp_prod_ack", int'(prod_ack), 0);
            check("bp_start_ignored", int'(ap_idle), 0);
        end

        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        prod_vld = 1'b0;
        acc_ack  = 1'b1;
        @(posedge ap_clk); #1;
        acc_ack  = 1'b0;
        @(negedge ap_clk);
        check("done_pulse", int'(ap_done), 1);
        check("idle_with_done", int'(ap_idle), 1);
        check("beat_count", beats, n);
        check("acc_out_retained", $signed(acc_out), exp_acc);
        check("sat_retained", int'(sat_flag), exp_sat);
        @(posedge ap_clk); #1;
        @(negedge ap_clk);
        check("done_one_cycle", int'(ap_done), 0);
        @(posedge ap_clk); #1;
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_ap_idle"},  int'(ap_idle), 1);
        check({pfx, "_ap_done"},  int'(ap_done), 0);
        check({pfx, "_prod_ack"}, int'(prod_ack), 0);
        check({pfx, "_acc_vld"},  int'(acc_vld), 0);
        check({pfx, "_acc_out"},  int'(acc_out), 0);
        check({pfx, "_sat_flag"}, int'(sat_flag), 0);
    endtask

    initial begin
        int dn;
        int res0;
        ap_rst    = 1'b1;
        ap_start  = 1'b0;
        len       = '0;
        prod_dout = '0;
        prod_vld  = 1'b0;
        acc_ack   = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check_reset_state("rst");
        @(posedge ap_clk); #1;

        // Basic sum
        prod_q = '{3, -2, 5, 1};
        run_job(4, 1'b0, 0);

        // Positive saturation, then a small job must clear acc and sat
        prod_q = {};
        for (int i = 0; i < 70; i++) prod_q.push_back(31);
        run_job(70, 1'b0, 0);
        prod_q = '{1};
        run_job(1, 1'b0, 0);

        // Negative saturation with input gaps
        prod_q = {};
        for (int i = 0; i < 70; i++) prod_q.push_back(-32);
        run_job(70, 1'b1, 0);

        // Zero length with backpressure
        prod_q = {};
        run_job(0, 1'b0, 5);

        // Reset in the middle of a job
        wait_idle();
        ap_start = 1'b1;
        len      = LW'(8);
        beats    = 0;
        @(posedge ap_clk); #1;
        ap_start  = 1'b0;
        prod_vld  = 1'b1;
        prod_dout = PW'(5);
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst   = 1'b1;
        prod_vld = 1'b0;
        check("beats_before_rst", beats, 3);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check_reset_state("midrst");
        @(posedge ap_clk); #1;
        @(negedge ap_clk);
        check("midrst_no_done", int'(ap_done), 0);
        @(posedge ap_clk); #1;

        prod_q = '{4, 4};
        run_job(2, 1'b0, 0);

        // Back-to-back jobs with ap_start held high
        sb_q.push_back('{2, 0});
        sb_q.push_back('{3, 0});
        res0 = results;
        wait_idle();
        ap_start  = 1'b1;
        len       = LW'(2);
        prod_vld  = 1'b1;
        prod_dout = PW'(1);
        acc_ack   = 1'b1;
        dn = 0;
        for (int c = 0; c < 200 && dn < 2; c++) begin
            @(negedge ap_clk);
            if (ap_done) begin
                dn++;
                if (dn == 1) len = LW'(3);
            end
            @(posedge ap_clk); #1;
            if (dn == 1 && ap_start) begin
                check("b2b_start_in_done_cycle", int'(ap_idle), 0);
                ap_start = 1'b0;
            end
        end
        check("b2b_dones", dn, 2);
        check("b2b_results", results - res0, 2);
        prod_vld = 1'b0;
        acc_ack  = 1'b0;
        @(posedge ap_clk); #1;

        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
